pixel_sched: RTL and testbench

PIXEL_SCHED -- requirements
Module: pixel_sched

---
 rtl/pixel_sched.sv | 135 +++++++++++++
 tb/tb_pixel_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sched.sv
// Raster coordinate scheduler: walks a centred HxV pixel grid and emits scaled,
// offset complex-plane coordinates per beat over a valid/ready stream.
module pixel_sched #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic               out_stream_aclk,
  input  logic               periph_reset,
  input  logic               run_en,
  input  logic               single_shot,
  input  logic               cfg_wr,
  input  logic signed [17:0] cfg_re_off,
  input  logic signed [17:0] cfg_im_off,
  input  logic [2:0]         cfg_shift,
  input  logic               out_ready,
  output logic               out_valid,
  output logic signed [17:0] c_re,
  output logic signed [17:0] c_im,
  output logic               first_pixel,
  output logic               last_re,
  output logic               last_pixel,
  output logic               frame_done,
  output logic [15:0]        frame_count,
  output logic               busy,
  output logic               cfg_pending
);

  localparam logic signed [9:0] X_MIN = 10'(-(H_ACTIVE / 2));
  localparam logic signed [9:0] X_MAX = 10'((H_ACTIVE / 2) - 1);
  localparam logic signed [8:0] Y_MAX = 9'(V_ACTIVE / 2);
  localparam logic signed [8:0] Y_MIN = 9'(-(V_ACTIVE / 2) + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state, state_nx;
  logic signed [17:0] re_off_p, im_off_p, re_off_a, im_off_a;
  logic [2:0]         shift_p, shift_a;
  logic signed [9:0]  x, x_nx;
  logic signed [8:0]  y, y_nx;
  logic signed [17:0] re_nx, im_nx;
  logic [2:0]         shift_nx;
  logic               xfer, at_last_re, at_last_pixel;

  // Wraps modulo 2^18 by construction; no saturation.
  function automatic logic signed [17:0] scale(input logic signed [17:0] p,
                                               input logic [2:0] s,
                                               input logic signed [17:0] off);
    return (p <<< s) + off;
  endfunction

  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx      = state;
    x_nx          = x;
    y_nx          = y;
    re_nx         = re_off_a;
    im_nx         = im_off_a;
    shift_nx      = shift_a;
    xfer          = 1'b0;
    at_last_re    = (x == X_MAX);
    at_last_pixel = at_last_re && (y == Y_MIN);
    case (state)
      IDLE: if (run_en) state_nx = LOAD;
      LOAD: begin
        state_nx = RUN;
        x_nx     = X_MIN;
        y_nx     = Y_MAX;
        re_nx    = re_off_p;
        im_nx    = im_off_p;
        shift_nx = shift_p;
      end
      RUN: if (out_ready) begin
        xfer = 1'b1;
        if (!at_last_re) begin
          x_nx = x + 10'sd1;
        end else begin
          x_nx = X_MIN;
          y_nx = at_last_pixel ? Y_MAX : y - 9'sd1;
        end
        // run_en is only consulted at frame end, so dropping it never truncates a frame.
        if (at_last_pixel) state_nx = (run_en && !single_shot) ? LOAD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed from the next counter/config values so the registered
  // coordinate always lines up with the beat that out_valid presents.
  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state       <= IDLE;
      x           <= X_MIN;
      y           <= Y_MAX;
      re_off_p    <= '0;
      im_off_p    <= '0;
      shift_p     <= '0;
      re_off_a    <= '0;
      im_off_a    <= '0;
      shift_a     <= '0;
      cfg_pending <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      c_re        <= {{8{X_MIN[9]}}, X_MIN};
      c_im        <= {{9{Y_MAX[8]}}, Y_MAX};
      first_pixel <= 1'b1;
      last_re     <= 1'b0;
      last_pixel  <= 1'b0;
    end else begin
      state    <= state_nx;
      x        <= x_nx;
      y        <= y_nx;
      re_off_a <= re_nx;
      im_off_a <= im_nx;
      shift_a  <= shift_nx;
      if (cfg_wr) begin
        re_off_p    <= cfg_re_off;
        im_off_p    <= cfg_im_off;
        shift_p     <= cfg_shift;
        cfg_pending <= 1'b1;
      end else if (state == LOAD) begin
        cfg_pending <= 1'b0;
      end
      frame_done <= xfer && at_last_pixel;
      if (xfer && at_last_pixel) frame_count <= frame_count + 16'd1;
      c_re        <= scale({{8{x_nx[9]}}, x_nx}, shift_nx, re_nx);
      c_im        <= scale({{9{y_nx[8]}}, y_nx}, shift_nx, im_nx);
      first_pixel <= (x_nx == X_MIN) && (y_nx == Y_MAX);
      last_re     <= (x_nx == X_MAX);
      last_pixel  <= (x_nx == X_MAX) && (y_nx == Y_MIN);
    end
  end

endmodule

// File: tb/tb_pixel_sched.sv
// Directed bench for pixel_sched on a reduced 16x8 raster (x -8..7, y 4..-3, 128 beats per frame)
// so whole frames, frame boundaries and back-to-back frames fit in a short run.
module tb_pixel_sched;

  logic               clk = 1'b0;
  logic               periph_reset, run_en, single_shot, cfg_wr, out_ready;
  logic signed [17:0] cfg_re_off, cfg_im_off;
  logic [2:0]         cfg_shift;
  logic               out_valid, first_pixel, last_re, last_pixel, frame_done, busy, cfg_pending;
  logic signed [17:0] c_re, c_im;
  logic [15:0]        frame_count;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  pixel_sched #(.H_ACTIVE(16), .V_ACTIVE(8)) dut (
    .out_stream_aclk(clk),
    .periph_reset(periph_reset),
    .run_en(run_en),
    .single_shot(single_shot),
    .cfg_wr(cfg_wr),
    .cfg_re_off(cfg_re_off),
    .cfg_im_off(cfg_im_off),
    .cfg_shift(cfg_shift),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .c_re(c_re),
    .c_im(c_im),
    .first_pixel(first_pixel),
    .last_re(last_re),
    .last_pixel(last_pixel),
    .frame_done(frame_done),
    .frame_count(frame_count),
    .busy(busy),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge too.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic setCfg(input int re, input int im, input int sh);
    cfg_wr     = 1'b1;
    cfg_re_off = 18'(re);
    cfg_im_off = 18'(im);
    cfg_shift  = 3'(sh);
  endtask

  initial begin
    int idx;
    int cyc;
    logic               rdy;
    logic signed [17:0] exp_re, exp_im;

    periph_reset = 1'b1;
    run_en       = 1'b0;
    single_shot  = 1'b0;
    cfg_wr       = 1'b0;
    cfg_re_off   = '0;
    cfg_im_off   = '0;
    cfg_shift    = '0;
    out_ready    = 1'b0;
    applyStimulus(2);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", frame_count, 0);
    checkOutput("rst_pending", cfg_pending, 0);
    checkOutput("rst_done", frame_done, 0);
    checkOutput("rst_c_re", c_re, -8);
    checkOutput("rst_c_im", c_im, 4);
    checkOutput("rst_first", first_pixel, 1);

    // Frame 1: zero config, full-rate ready, run_en dropped mid-frame.
    periph_reset = 1'b0;
    run_en       = 1'b1;
    out_ready    = 1'b1;
    applyStimulus(1);
    checkOutput("load_valid", out_valid, 0);
    checkOutput("load_busy", busy, 1);
    applyStimulus(1);
    checkOutput("f1_valid", out_valid, 1);
    checkOutput("f1_c_re", c_re, -8);
    checkOutput("f1_c_im", c_im, 4);
    checkOutput("f1_first", first_pixel, 1);
    checkOutput("f1_last_re0", last_re, 0);
    applyStimulus(15);
    checkOutput("f1_b16_last_re", last_re, 1);
    checkOutput("f1_b16_c_re", c_re, 7);
    applyStimulus(1);
    checkOutput("f1_b17_c_re", c_re, -8);
    checkOutput("f1_b17_c_im", c_im, 3);
    checkOutput("f1_b17_last_re", last_re, 0);
    checkOutput("f1_b17_first", first_pixel, 0);
    run_en = 1'b0;
    applyStimulus(111);
    checkOutput("f1_end_valid", out_valid, 1);
    checkOutput("f1_end_last_pixel", last_pixel, 1);
    checkOutput("f1_end_c_re", c_re, 7);
    checkOutput("f1_end_c_im", c_im, -3);
    checkOutput("f1_end_done0", frame_done, 0);
    applyStimulus(1);
    checkOutput("f1_done", frame_done, 1);
    checkOutput("f1_count", frame_count, 1);
    checkOutput("f1_idle_valid", out_valid, 0);
    checkOutput("f1_idle_busy", busy, 0);
    applyStimulus(1);
    checkOutput("f1_done_pulse", frame_done, 0);

    // Pending config, then a second write during LOAD that must not take effect yet.
    setCfg(1000, -5, 2);
    applyStimulus(1);
    cfg_wr = 1'b0;
    checkOutput("cfg_pending_set", cfg_pending, 1);
    run_en      = 1'b1;
    single_shot = 1'b1;
    applyStimulus(1);
    checkOutput("f2_load_valid", out_valid, 0);
    setCfg(-131072, 7, 7);
    applyStimulus(1);
    cfg_wr = 1'b0;
    checkOutput("f2_pending_kept", cfg_pending, 1);
    checkOutput("f2_c_re", c_re, -280 + 1248);
    checkOutput("f2_c_im", c_im, 11);

    // Frame 2 under random backpressure: per-cycle model of the presented beat.
    idx = 0;
    cyc = 0;
    while (idx < 128 && cyc < 2000) begin
      exp_re = 18'(((idx % 16) - 8) * 4 + 1000);
      exp_im = 18'((4 - idx / 16) * 4 - 5);
      checkOutput("f2_beat",
                  longint'({out_valid, first_pixel, last_re, last_pixel, c_re, c_im}),
                  longint'({1'b1, (idx == 0), (idx % 16 == 15), (idx == 127), exp_re, exp_im}));
      rdy       = 1'($urandom_range(0, 1));
      out_ready = rdy;
      applyStimulus(1);
      if (rdy) idx++;
      cyc++;
    end
    checkOutput("f2_transfers", idx, 128);
    checkOutput("f2_done", frame_done, 1);
    checkOutput("f2_count", frame_count, 2);
    checkOutput("f2_single_shot_idle", busy, 0);
    checkOutput("f2_pending_after", cfg_pending, 1);

    // Frame 3 uses the LOAD-cycle write (wrapping), then back-to-back into frame 4.
    single_shot = 1'b0;
    out_ready   = 1'b1;
    applyStimulus(2);
    checkOutput("f3_valid", out_valid, 1);
    checkOutput("f3_c_re_wrap", c_re, 130048);
    checkOutput("f3_c_im", c_im, 519);
    checkOutput("f3_pending_clr", cfg_pending, 0);
    setCfg(5, 6, 0);
    applyStimulus(1);
    cfg_wr = 1'b0;
    checkOutput("f3_midframe_pending", cfg_pending, 1);
    checkOutput("f3_b2_c_re", c_re, 130176);
    applyStimulus(126);
    checkOutput("f3_end_last_pixel", last_pixel, 1);
    checkOutput("f3_end_c_re", c_re, -130176);
    checkOutput("f3_end_c_im", c_im, -377);
    applyStimulus(1);
    checkOutput("f3_done", frame_done, 1);
    checkOutput("f3_count", frame_count, 3);
    checkOutput("f3_bubble_valid", out_valid, 0);
    checkOutput("f3_bubble_busy", busy, 1);
    applyStimulus(1);
    checkOutput("f4_valid", out_valid, 1);
    checkOutput("f4_c_re", c_re, -3);
    checkOutput("f4_c_im", c_im, 10);
    checkOutput("f4_done_pulse", frame_done, 0);
    checkOutput("f4_pending_clr", cfg_pending, 0);

    // Reset in the middle of frame 4 aborts it, then a clean restart.
    applyStimulus(20);
    periph_reset = 1'b1;
    applyStimulus(1);
    checkOutput("mrst_valid", out_valid, 0);
    checkOutput("mrst_count", frame_count, 0);
    checkOutput("mrst_done", frame_done, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_c_re", c_re, -8);
    periph_reset = 1'b0;
    applyStimulus(2);
    checkOutput("restart_valid", out_valid, 1);
    checkOutput("restart_c_re", c_re, -8);
    checkOutput("restart_c_im", c_im, 4);
    checkOutput("restart_first", first_pixel, 1);
    checkOutput("restart_count", frame_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
